credit_sender: RTL and testbench
================================

// Module: credit_sender
// PURPOSE
//  Transmit end of the credit-based link: accepts words on an upstream ready/valid push port
//  and forwards them on the pop port only while it holds a credit. The receiver returns one
//  credit per pop_credit pulse. Sits between a producer and the link; pairs with the receiver.
// PARAMETERS
//  DATA_WIDTH   8  width of push_data/pop_data
//  MAX_CREDITS  4  credit counter ceiling; CW = $clog2(MAX_CREDITS+1)
// PORTS
//  clk                    in   1   single clock, all state on posedge
//  rst                    in   1   synchronous, active-high reset
//  pop_sender_in_reset    out  1   = rst (combinational)
//  pop_receiver_in_reset  in   1   far end in reset; treated as local reset
//  push_valid             in   1   upstream word valid
//  push_ready             out  1   upstream may transfer this cycle
//  push_data              in   DW  upstream word
//  pop_valid              out  1   word sent on link (consumes one credit)
//  pop_data               out  DW  link word
//  pop_credit             in   1   one credit returned by receiver
//  credit_initial         in   CW  counter load value while in reset
//  credit_withhold        in   CW  credits reserved (not spendable)
//  credit_count           out  CW  current credit count
//  credit_available       out  1   credit_count > credit_withhold
// BEHAVIOUR
//  - in_reset = rst | pop_receiver_in_reset; while high: credit_count <= min(credit_initial,MAX_CREDITS),
//    push_ready=0, pop_valid=0, pop_credit ignored. Takes priority over every clock-edge update.
//  - push_ready = credit_available & !in_reset (combinational, no dependency on push_valid).
//  - send = push_valid & push_ready. Default build: pop_valid = send, pop_data = push_data,
//    combinational, zero latency. pop_data follows push_data even when pop_valid=0.
//  - Counter per cycle: send&!pop_credit -> -1; pop_credit&!send -> +1 saturating at MAX_CREDITS;
//    both -> unchanged; neither -> unchanged. Never wraps below 0 (send requires count>withhold>=0).
//  - credit_withhold >= credit_count blocks sending, count still accepts returns.
//  - Receiver reset mid-stream: any credit in flight is discarded; counter reloads from credit_initial.
//  - credit_count reset value = credit_initial clamp; credit_available = 0 when count <= withhold.
// CONFIGURATION
//  CREDIT_SENDER_REG_OUTPUT_EN defined: pop_valid/pop_data registered -> one cycle latency;
//    pop_valid reg cleared to 0 on in_reset; credit decrement still at the accepting edge,
//    push_ready unchanged. pop_data reg loads only on send (holds otherwise).
//  Undefined: combinational pass-through as above.
// TESTING
//  1 rst=1,credit_initial=3 one cycle -> credit_count=3, push_ready=0, pop_valid=0,
//    pop_sender_in_reset=1; after release push_ready=1.
//  2 count=3, push_valid=1 for 3 cycles, data A1,A2,A3 -> pop_valid 1 each cycle with matching data,
//    count 2,1,0; 4th cycle push_ready=0, pop_valid=0.
//  3 count=4 (MAX), pop_credit=1, push_valid=0 -> count stays 4; then push_valid=1 & pop_credit=1
//    together -> count stays 4, pop_valid=1.
//  4 count=2, credit_withhold=2 -> credit_available=0, push_ready=0; pop_credit pulse -> count=3,
//    credit_available=1; one send -> count=2.
//  5 count=1, pop_receiver_in_reset=1 with pop_credit=1, credit_initial=2 -> next edge count=2
//    (not 2 by increment, verify with credit_initial=0 -> 0), pop_valid=0 throughout.
//  6 REG_OUTPUT_EN: push word B7 at edge N -> pop_valid=1, pop_data=B7 during cycle N+1, count
//    decremented after edge N; rst asserted at N -> pop_valid=0 after edge N.

Source files
------------

// File: rtl/credit_sender.sv
// -----------------------------------------------------------------------------
// credit_sender
//   Transmit end of a credit-based link. Words arrive on an upstream
//   ready/valid push port and are forwarded on the pop port only while a
//   spendable credit is held. The receiver hands one credit back per
//   i_pop_credit pulse.
//
// Configuration macro:
//   CREDIT_SENDER_REG_OUTPUT_EN  defined   -> o_pop_valid/o_pop_data registered
//                                             (one cycle latency)
//                                undefined -> combinational pass-through
//
// Ports:
//   i_clk                   clock, all state on posedge
//   i_rst                   synchronous active-high reset
//   o_pop_sender_in_reset   mirrors i_rst (combinational)
//   i_pop_receiver_in_reset far end in reset, treated as a local reset
//   i_push_valid            upstream word valid
//   o_push_ready            upstream may transfer this cycle
//   i_push_data             upstream word
//   o_pop_valid             word sent on the link (consumes one credit)
//   o_pop_data              link word
//   i_pop_credit            one credit returned by the receiver
//   i_credit_initial        counter load value while in reset
//   i_credit_withhold       credits reserved (not spendable)
//   o_credit_count          current credit count
//   o_credit_available      o_credit_count > i_credit_withhold
// -----------------------------------------------------------------------------
module credit_sender #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_CREDITS = 4,
  localparam int CW         = $clog2(MAX_CREDITS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_pop_sender_in_reset,
  input  logic                  i_pop_receiver_in_reset,
  input  logic                  i_push_valid,
  output logic                  o_push_ready,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  output logic                  o_pop_valid,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  input  logic                  i_pop_credit,
  input  logic [CW-1:0]         i_credit_initial,
  input  logic [CW-1:0]         i_credit_withhold,
  output logic [CW-1:0]         o_credit_count,
  output logic                  o_credit_available
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_CREDITS);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [CW-1:0] r_credit_count;
  logic [CW-1:0] w_count_next;
  logic [CW-1:0] w_init_clamped;
  logic          w_in_reset;
  logic          w_credit_available;
  logic          w_push_ready;
  logic          w_send;

  // Either end being in reset holds the whole link in reset.
  assign w_in_reset         = i_rst | i_pop_receiver_in_reset;
  assign w_credit_available = (r_credit_count > i_credit_withhold);
  assign w_push_ready       = w_credit_available & ~w_in_reset;
  assign w_send             = i_push_valid & w_push_ready;

  assign o_pop_sender_in_reset = i_rst;
  assign o_push_ready          = w_push_ready;
  assign o_credit_count        = r_credit_count;
  assign o_credit_available    = w_credit_available;

  // Reload value: the initial credit count can never exceed the ceiling.
  always_comb begin
    if (i_credit_initial > MAX_C) begin
      w_init_clamped = MAX_C;
    end else begin
      w_init_clamped = i_credit_initial;
    end
  end

  // Next credit count from the send/return pair; a simultaneous send and
  // return cancel out. Underflow is impossible because sending needs
  // count > withhold >= 0.
  always_comb begin
    w_count_next = r_credit_count;
    case ({w_send, i_pop_credit})
      2'b10: w_count_next = r_credit_count - ONE_C;
      2'b01: begin
        if (r_credit_count >= MAX_C) begin
          w_count_next = MAX_C;
        end else begin
          w_count_next = r_credit_count + ONE_C;
        end
      end
      default: w_count_next = r_credit_count;
    endcase
  end

  // Credit counter; reset (local or far end) reloads and drops in-flight returns.
  always_ff @(posedge i_clk) begin
    if (w_in_reset) begin
      r_credit_count <= w_init_clamped;
    end else begin
      r_credit_count <= w_count_next;
    end
  end

`ifdef CREDIT_SENDER_REG_OUTPUT_EN
  logic                  r_pop_valid;
  logic [DATA_WIDTH-1:0] r_pop_data;

  // Registered link valid; the credit is still consumed at the accepting edge.
  always_ff @(posedge i_clk) begin
    if (w_in_reset) begin
      r_pop_valid <= 1'b0;
    end else begin
      r_pop_valid <= w_send;
    end
  end

  // Link data register only captures on an accepted word and holds otherwise.
  always_ff @(posedge i_clk) begin
    if (w_send) begin
      r_pop_data <= i_push_data;
    end else begin
      r_pop_data <= r_pop_data;
    end
  end

  assign o_pop_valid = r_pop_valid;
  assign o_pop_data  = r_pop_data;
`else
  // Zero-latency pass-through: data follows the push port even when idle.
  assign o_pop_valid = w_send;
  assign o_pop_data  = i_push_data;
`endif

endmodule

// File: tb/tb_credit_sender.sv
module tb_credit_sender;

  localparam int DW      = 8;
  localparam int MAXC    = 4;
  localparam int CW      = 3;

  logic          clk;
  logic          rst;
  logic          sender_in_reset;
  logic          rx_in_reset;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic          pop_credit;
  logic [CW-1:0] credit_initial;
  logic [CW-1:0] credit_withhold;
  logic [CW-1:0] credit_count;
  logic          credit_available;

  int n_vectors    = 0;
  int n_miscompare = 0;

  // Reference model state: plain integer credit balance plus the link word
  // as the receiver would see it.
  int          m_credits;
  bit          m_reg_valid;
  logic [DW-1:0] m_reg_data;
  bit          m_reg_data_known;

  credit_sender #(.DATA_WIDTH(DW), .MAX_CREDITS(MAXC)) dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .o_pop_sender_in_reset   (sender_in_reset),
    .i_pop_receiver_in_reset (rx_in_reset),
    .i_push_valid            (push_valid),
    .o_push_ready            (push_ready),
    .i_push_data             (push_data),
    .o_pop_valid             (pop_valid),
    .o_pop_data              (pop_data),
    .i_pop_credit            (pop_credit),
    .i_credit_initial        (credit_initial),
    .i_credit_withhold       (credit_withhold),
    .o_credit_count          (credit_count),
    .o_credit_available      (credit_available)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    assert (obs === exp) else begin
      n_miscompare++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs against the model,
  // then advance the model across the posedge.
  task automatic cycle(input bit r, input bit rr, input bit pv, input logic [DW-1:0] pd,
                       input bit pc, input int init, input int wh);
    bit in_rst;
    bit exp_ready;
    bit exp_send;
    rst             = r;
    rx_in_reset     = rr;
    push_valid      = pv;
    push_data       = pd;
    pop_credit      = pc;
    credit_initial  = 3'(init);
    credit_withhold = 3'(wh);
    #1;
    in_rst    = r || rr;
    exp_ready = !in_rst && (m_credits > wh);
    exp_send  = pv && exp_ready;
    chk("count", 32'(credit_count), 32'(m_credits));
    chk("available", 32'(credit_available), 32'(m_credits > wh));
    chk("push_ready", 32'(push_ready), 32'(exp_ready));
    chk("sender_in_reset", 32'(sender_in_reset), 32'(r));
`ifdef CREDIT_SENDER_REG_OUTPUT_EN
    chk("pop_valid", 32'(pop_valid), 32'(m_reg_valid));
    if (m_reg_data_known) chk("pop_data", 32'(pop_data), 32'(m_reg_data));
`else
    chk("pop_valid", 32'(pop_valid), 32'(exp_send));
    chk("pop_data", 32'(pop_data), 32'(pd));
`endif
    @(posedge clk);
    if (in_rst) begin
      m_credits   = (init > MAXC) ? MAXC : init;
      m_reg_valid = 1'b0;
    end else begin
      m_credits   = m_credits - int'(exp_send) + int'(pc);
      if (m_credits > MAXC) m_credits = MAXC;
      m_reg_valid = exp_send;
    end
    if (exp_send) begin
      m_reg_data       = pd;
      m_reg_data_known = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    m_reg_valid      = 1'b0;
    m_reg_data       = '0;
    m_reg_data_known = 1'b0;
    // Bring the DUT out of X with a plain reset cycle before any checks.
    rst = 1'b1; rx_in_reset = 1'b0; push_valid = 1'b0; push_data = 8'h00;
    pop_credit = 1'b0; credit_initial = 3'd3; credit_withhold = 3'd0;
    @(posedge clk);
    @(negedge clk);
    m_credits = 3;

    // Reset holds count at the initial value, blocks the port
    cycle(1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 3, 0);
    chk("t1_count", 32'(credit_count), 32'd3);
    // Released: ready with credits in hand; three words drain the credits
    cycle(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 3, 0);
    chk("t2_count_a", 32'(credit_count), 32'd2);
    cycle(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 3, 0);
    cycle(1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 3, 0);
    chk("t2_count_c", 32'(credit_count), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'hA4, 1'b0, 3, 0);
    chk("t2_ready_empty", 32'(push_ready), 32'd0);

    // Return credits up to and past the ceiling
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3, 0);
    chk("t3_saturate", 32'(credit_count), 32'(MAXC));
    cycle(1'b0, 1'b0, 1'b1, 8'h5C, 1'b1, 3, 0);
    chk("t3_both", 32'(credit_count), 32'(MAXC));

    // Withhold blocks sending while returns still count
    cycle(1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 3, 0);
    cycle(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 3, 0);
    cycle(1'b0, 1'b0, 1'b1, 8'h23, 1'b0, 3, 2);
    chk("t4_blocked", 32'(credit_count), 32'd2);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3, 2);
    cycle(1'b0, 1'b0, 1'b1, 8'h24, 1'b0, 3, 2);
    chk("t4_after_send", 32'(credit_count), 32'd2);

    // Receiver reset discards the in-flight credit and reloads
    cycle(1'b0, 1'b0, 1'b1, 8'h31, 1'b0, 3, 0);
    chk("t5_count1", 32'(credit_count), 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 8'h32, 1'b1, 2, 0);
    chk("t5_reload2", 32'(credit_count), 32'd2);
    cycle(1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 0, 0);
    chk("t5_reload0", 32'(credit_count), 32'd0);
    // Oversized initial value is clamped
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 7, 0);
    chk("clamp", 32'(credit_count), 32'(MAXC));

    // Send at edge N then reset: the registered valid must drop
    cycle(1'b0, 1'b0, 1'b1, 8'hB7, 1'b0, 4, 0);
    cycle(1'b1, 1'b0, 1'b1, 8'hB8, 1'b0, 4, 0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4, 0);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 49) == 0),
            1'($urandom), 8'($urandom), 1'($urandom),
            int'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
    $finish;
  end

endmodule
